alu_arbiter: RTL

//  Shares one 8-bit registered ALU (alu) between NREQ requesters. Round-robin arbitration

---
 rtl/alu_ctrl_pkg.sv | 40 ++++
 rtl/alu_rsp_fifo.sv | 59 +++++
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings for the arbiter, its requesters and the bench.
// Sel[2] picks the arithmetic or logic group, Sel[1:0] the function, Sel[4:3] the shift stage.
package alu_ctrl_pkg;

    localparam int SEL_W         = 5;
    localparam int SEL_GROUP_BIT = 2;

    localparam logic [1:0] ARITH_A    = 2'b00;
    localparam logic [1:0] ARITH_ADDC = 2'b01;
    localparam logic [1:0] ARITH_ADD  = 2'b10;
    localparam logic [1:0] ARITH_B    = 2'b11;

    localparam logic [1:0] LOGIC_AND   = 2'b00;
    localparam logic [1:0] LOGIC_OR    = 2'b01;
    localparam logic [1:0] LOGIC_XOR   = 2'b10;
    localparam logic [1:0] LOGIC_NOT_A = 2'b11;

    typedef enum logic [1:0] {
        SHIFT_PASS  = 2'b00,
        SHIFT_LEFT  = 2'b01,
        SHIFT_RIGHT = 2'b10,
        SHIFT_ZERO  = 2'b11
    } shift_e;

    // Full opcodes with the shift stage in pass mode.
    localparam logic [SEL_W-1:0] OP_AND    = 5'b00000;
    localparam logic [SEL_W-1:0] OP_OR     = 5'b00001;
    localparam logic [SEL_W-1:0] OP_XOR    = 5'b00010;
    localparam logic [SEL_W-1:0] OP_NOT_A  = 5'b00011;
    localparam logic [SEL_W-1:0] OP_PASS_A = 5'b00100;
    localparam logic [SEL_W-1:0] OP_ADDC   = 5'b00101;
    localparam logic [SEL_W-1:0] OP_ADD    = 5'b00110;
    localparam logic [SEL_W-1:0] OP_PASS_B = 5'b00111;

    // Minimum requester ID width for a given requester count.
    function automatic int calc_idw(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// In-order response buffer holding {id, result} entries for the ALU arbiter.
// The head entry is presented combinationally and reads as zero while empty.
module alu_rsp_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // NOTE: storage is deliberately not reset; only pointers and count are, and the
    // head is masked to zero while empty so no stale entry is ever visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full      = (count == CNTW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one registered ALU between NREQ requesters, with
// credit-based issue so every in-flight result is guaranteed a response buffer slot.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int ALU_LAT   = 1,
    parameter int RSP_DEPTH = ALU_LAT + 1,
    parameter int IDW       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [8*NREQ-1:0]     req_a,
    input  logic [8*NREQ-1:0]     req_b,
    input  logic [SEL_W*NREQ-1:0] req_sel,
    input  logic [NREQ-1:0]       req_cin,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [SEL_W-1:0]      alu_sel,
    output logic                  alu_cin,
    input  logic [7:0]            alu_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [7:0]            rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy,
    output logic [15:0]           issue_cnt
);

    localparam int OCCW = $clog2(RSP_DEPTH+1);
    localparam int CW   = $clog2(RSP_DEPTH+ALU_LAT+1) + 1;

    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     hi_id;
    logic [IDW-1:0]     lo_id;
    logic               hi_found;
    logic               lo_found;
    logic               can_issue;
    logic               issue;
    logic [ALU_LAT-1:0] pipe_v;
    logic [IDW-1:0]     pipe_id [ALU_LAT];
    logic [CW-1:0]      inflight_cnt;
    logic [CW-1:0]      credit_sum;
    logic [OCCW-1:0]    occ;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    // Requesters after last_grant win over those at or before it; lowest index first.
    // NOTE: every combinational output gets a default before the loop so no path
    // leaves a variable unassigned and infers a latch.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IDW'(i) > last_grant) begin
                    hi_found = 1'b1;
                    hi_id    = IDW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_id    = IDW'(i);
                end
            end
        end
        grant_id = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < ALU_LAT; i++) begin
            inflight_cnt = inflight_cnt + CW'(pipe_v[i]);
        end
    end

    assign pop        = rsp_valid & rsp_ready;
    assign push       = pipe_v[ALU_LAT-1];
    assign credit_sum = CW'(occ) + inflight_cnt - CW'(pop);
    // Gated by rst_n so nothing is readied while reset is held.
    assign can_issue  = rst_n & (credit_sum < CW'(RSP_DEPTH));
    assign issue      = (hi_found | lo_found) & can_issue;

    always_comb begin
        req_ready = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_sel   = '0;
        alu_cin   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (issue && (grant_id == IDW'(i))) begin
                req_ready[i] = 1'b1;
                alu_a        = req_a[8*i +: 8];
                alu_b        = req_b[8*i +: 8];
                alu_sel      = req_sel[SEL_W*i +: SEL_W];
                alu_cin      = req_cin[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDW'(NREQ-1);
            issue_cnt  <= '0;
            pipe_v     <= '0;
            for (int i = 0; i < ALU_LAT; i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            if (issue) begin
                last_grant <= grant_id;
                issue_cnt  <= issue_cnt + 16'd1;
            end
            for (int i = ALU_LAT-1; i > 0; i--) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_id[i] <= pipe_id[i-1];
            end
            pipe_v[0]  <= issue;
            pipe_id[0] <= grant_id;
        end
    end

    alu_rsp_fifo #(
        .WIDTH (8 + IDW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({pipe_id[ALU_LAT-1], alu_y}),
        .pop       (pop),
        .head_data ({rsp_id, rsp_data}),
        .count     (occ),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_valid = ~fifo_empty;
    assign busy      = (|pipe_v) | ~fifo_empty;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop))
        else $error("alu_arbiter: push into full response FIFO");

endmodule
